multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: ILLEGAL_TO_FETCH, default 1, meaning an unknown opcode returns to FETCH; when 0 it parks in HALT.
REQ-002 The module SHALL have these ports: clk, input, 1, system clock.
REQ-003 The module SHALL have these ports: rst, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-004 The module SHALL have these ports: opcode, input, 6, IR[31:26], sampled in DECODE.
REQ-005 The module SHALL have these ports: zero, input, 1, ALU zero flag for beq.
REQ-006 Outputs (1 bit each): pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, ext_op (1 = sign-extend imm16, 0 = zero-extend), illegal_op.
REQ-007 Outputs (2 bits each): alu_src_b, alu_op, pc_source. Output state[3:0] is for debug.

Function
REQ-008 Moore FSM; all outputs SHALL decode from the registered state only; state advances once per clk.
REQ-009 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, HALT 15.
REQ-010 FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_op=00, pc_source=00, pc_write=1; next DECODE.
REQ-011 DECODE: alu_src_b=11, ext_op=1 (branch offset), alu_op=00; next by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000/001100/001101 -> IEXEC, others -> illegal handling.
REQ-012 MEMADR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=00; lw -> MEMRD, sw -> MEMWR.
REQ-013 MEMRD: mem_read=1, i_or_d=1 -> MEMWB. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
REQ-014 MEMWR: mem_write=1, i_or_d=1 -> FETCH.
REQ-015 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-016 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH; the PC update SHALL be gated by zero externally (pc_write_cond AND zero).
REQ-017 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-018 IEXEC: alu_src_a=1, alu_src_b=10, alu_op=00 for addi, 11 for andi/ori; ext_op=1 for addi and 0 for andi/ori -> IWB. IWB: reg_write=1, reg_dst=0, mem_to_reg=0, ext_op held as in IEXEC -> FETCH.
REQ-019 The opcode SHALL be latched into an internal register on exit from DECODE; MEMADR/IEXEC/IWB SHALL use the latched value, not the live input.
REQ-020 Illegal opcode in DECODE: illegal_op=1 for exactly one cycle (the next cycle); next FETCH if ILLEGAL_TO_FETCH=1, else HALT.
REQ-021 HALT: all write enables 0; remain until rst.
REQ-022 Outputs not listed for a state SHALL be 0. Latency: lw 5, sw/R/addi/andi/ori 4, beq/j 3 cycles.

Reset
REQ-023 When rst is high at a clk edge, state SHALL become FETCH, latched opcode 000000, and illegal_op 0, including mid-instruction.
REQ-024 While rst is high, pc_write, pc_write_cond, mem_write, reg_write and ir_write SHALL be forced to 0.
REQ-025 There SHALL be no asynchronous behaviour.

Structure
REQ-026 A shared package SHALL hold state encodings, opcode constants, and the alu_op/alu_src_b/pc_source encodings for use by the datapath and the bench.
REQ-027 There SHALL be one sub-module, mc_opcode_decode, combinational: opcode -> {next-state-after-DECODE, is_legal, ext_op_imm, alu_op_imm}.

Verification
REQ-028 lw (opcode 100011) after reset: the state sequence SHALL be 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-029 andi (001100) then addi (001000): ext_op SHALL be 0 during IEXEC/IWB for andi and 1 for addi; alu_op SHALL be 11 and then 00.
REQ-030 beq with zero=1 vs zero=0: pc_write_cond=1 and pc_source=01 only in BRANCH; the external PC enable SHALL be 1 and 0 respectively.
REQ-031 Opcode 111111: illegal_op SHALL pulse one cycle; the next state SHALL be FETCH (default) or HALT with ILLEGAL_TO_FETCH=0, with no writes thereafter.
REQ-032 rst asserted during MEMWR: mem_write SHALL be 0 in that cycle; the next state SHALL be FETCH.
REQ-033 The opcode input SHALL change during MEMADR: the latched opcode SHALL still select MEMRD vs MEMWR.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes
// and the datapath mux/ALU select codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  localparam logic [1:0] SRCB_REG       = 2'b00;
  localparam logic [1:0] SRCB_FOUR      = 2'b01;
  localparam logic [1:0] SRCB_IMM       = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_opcode_decode.sv
// Combinational opcode classifier: picks the state following DECODE and the
// immediate-handling controls used by IEXEC/IWB.
module mc_opcode_decode
  import multicycle_control_pkg::*;
(
  input  logic [5:0] opcode_i,
  output state_t     next_state_o,
  output logic       is_legal_o,
  output logic       ext_op_imm_o,
  output logic [1:0] alu_op_imm_o
);

  always_comb begin
    next_state_o = S_FETCH;
    is_legal_o   = 1'b1;
    ext_op_imm_o = 1'b1;
    alu_op_imm_o = ALUOP_ADD;
    case (opcode_i)
      OP_LW, OP_SW: next_state_o = S_MEMADR;
      OP_RTYPE:     next_state_o = S_EXEC;
      OP_BEQ:       next_state_o = S_BRANCH;
      OP_J:         next_state_o = S_JUMP;
      OP_ADDI:      next_state_o = S_IEXEC;
      // Logical immediates zero-extend and use the logic ALU function.
      OP_ANDI, OP_ORI: begin
        next_state_o = S_IEXEC;
        ext_op_imm_o = 1'b0;
        alu_op_imm_o = ALUOP_LOGIC;
      end
      default:      is_legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS subset (lw/sw/R/beq/j/addi/andi/ori).
// Branch PC update is qualified by the ALU zero flag outside this block.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit ILLEGAL_TO_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       ext_op,
  output logic       illegal_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic [5:0] opcode_q;
  logic       ext_imm_q;
  logic [1:0] alu_imm_q;
  logic       illegal_q, illegal_d;

  state_t     dec_next;
  logic       dec_legal;
  logic       dec_ext;
  logic [1:0] dec_alu;

  // zero is consumed by the external PC-enable gate; only accepted here.
  logic unused_zero;
  assign unused_zero = zero;

  mc_opcode_decode u_decode (
    .opcode_i     (opcode),
    .next_state_o (dec_next),
    .is_legal_o   (dec_legal),
    .ext_op_imm_o (dec_ext),
    .alu_op_imm_o (dec_alu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opcode_q  <= 6'b000000;
      ext_imm_q <= 1'b0;
      alu_imm_q <= ALUOP_ADD;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == S_DECODE) begin
        opcode_q  <= opcode;
        ext_imm_q <= dec_ext;
        alu_imm_q <= dec_alu;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (dec_legal) begin
          state_d = dec_next;
        end else begin
          state_d   = ILLEGAL_TO_FETCH ? S_FETCH : S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: state_d = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    ext_op        = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SHIFT;
        ext_op    = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = alu_imm_q;
        ext_op    = ext_imm_q;
      end
      S_IWB: begin
        reg_write = 1'b1;
        ext_op    = ext_imm_q;
      end
      default: ;
    endcase
    // Architectural writes are suppressed for the whole cycle reset is held.
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      ir_write      = 1'b0;
    end
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction expands into its
// expected state path, and every cycle's full control word is compared.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  // Bits of the packed control word that reset must hold low.
  localparam logic [21:0] RESET_FORCED = 22'h332000;

  logic       clk = 1'b0;
  logic       rst;
  logic       zero;
  logic [5:0] opcode;
  wire [21:0] obsMain;
  wire [21:0] obsHalt;
  int         checks = 0;
  int         errors = 0;
  logic       prevIllegal = 1'b0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_write(obsMain[21]), .pc_write_cond(obsMain[20]), .i_or_d(obsMain[19]),
    .mem_read(obsMain[18]), .mem_write(obsMain[17]), .ir_write(obsMain[16]),
    .mem_to_reg(obsMain[15]), .reg_dst(obsMain[14]), .reg_write(obsMain[13]),
    .alu_src_a(obsMain[12]), .ext_op(obsMain[11]), .illegal_op(obsMain[10]),
    .alu_src_b(obsMain[9:8]), .alu_op(obsMain[7:6]), .pc_source(obsMain[5:4]),
    .state(obsMain[3:0])
  );

  multicycle_control #(.ILLEGAL_TO_FETCH(1'b0)) dutHalt (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_write(obsHalt[21]), .pc_write_cond(obsHalt[20]), .i_or_d(obsHalt[19]),
    .mem_read(obsHalt[18]), .mem_write(obsHalt[17]), .ir_write(obsHalt[16]),
    .mem_to_reg(obsHalt[15]), .reg_dst(obsHalt[14]), .reg_write(obsHalt[13]),
    .alu_src_a(obsHalt[12]), .ext_op(obsHalt[11]), .illegal_op(obsHalt[10]),
    .alu_src_b(obsHalt[9:8]), .alu_op(obsHalt[7:6]), .pc_source(obsHalt[5:4]),
    .state(obsHalt[3:0])
  );

  function automatic logic isLegal(input logic [5:0] op);
    return op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI};
  endfunction

  // Expected control word for a given state number, instruction and illegal flag.
  function automatic logic [21:0] ctlWord(input logic [3:0] st, input logic [5:0] op,
                                          input logic ill);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, ext;
    logic [1:0] srcb, aluop, pcsrc;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, ext} = '0;
    srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
    case (st)
      4'd0:  begin mr = 1; irw = 1; srcb = 2'b01; pcw = 1; end
      4'd1:  begin srcb = 2'b11; ext = 1; end
      4'd2:  begin srca = 1; srcb = 2'b10; ext = 1; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin srca = 1; aluop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; end
      4'd9:  begin pcw = 1; pcsrc = 2'b10; end
      4'd10: begin srca = 1; srcb = 2'b10; aluop = (op == OP_ADDI) ? 2'b00 : 2'b11;
                   ext = (op == OP_ADDI); end
      4'd11: begin rw = 1; ext = (op == OP_ADDI); end
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca, ext, ill, srcb, aluop, pcsrc, st};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic z, input logic r);
    opcode = op;
    zero   = z;
    rst    = r;
  endtask

  task automatic resetDut();
    applyStimulus(6'($urandom), 1'b0, 1'b1);
    @(posedge clk); #2;
    checkOutput("resetMain", obsMain, ctlWord(4'd0, 6'd0, 1'b0) & ~RESET_FORCED);
    checkOutput("resetHalt", obsHalt, ctlWord(4'd0, 6'd0, 1'b0) & ~RESET_FORCED);
    prevIllegal = 1'b0;
  endtask

  // Runs one instruction; abortAt >= 0 raises reset in that path step.
  task automatic runInstr(input logic [5:0] op, input logic z, input int abortAt);
    int path[$];
    logic [3:0] st;
    logic [21:0] exp;
    if (op == OP_LW)                           path = '{0, 1, 2, 3, 4};
    else if (op == OP_SW)                      path = '{0, 1, 2, 5};
    else if (op == OP_RTYPE)                   path = '{0, 1, 6, 7};
    else if (op == OP_BEQ)                     path = '{0, 1, 8};
    else if (op == OP_J)                       path = '{0, 1, 9};
    else if (op inside {OP_ADDI, OP_ANDI, OP_ORI}) path = '{0, 1, 10, 11};
    else                                       path = '{0, 1};
    for (int k = 0; k < path.size(); k++) begin
      st = 4'(path[k]);
      applyStimulus((st == 4'd1) ? op : 6'($urandom), z, k == abortAt);
      #1;
      exp = ctlWord(st, op, (k == 0) && prevIllegal);
      if (k == abortAt) exp = exp & ~RESET_FORCED;
      checkOutput($sformatf("op%b step%0d", op, k), {10'd0, obsMain}, {10'd0, exp});
      if (st == 4'd8 && k != abortAt)
        checkOutput("pcEnable", {31'd0, obsMain[20] & zero}, {31'd0, z});
      @(posedge clk); #2;
      if (k == abortAt) begin
        checkOutput("abortToFetch", obsMain, ctlWord(4'd0, 6'd0, 1'b0) & ~RESET_FORCED);
        prevIllegal = 1'b0;
        return;
      end
    end
    prevIllegal = !isLegal(op);
  endtask

  task automatic illegalTest();
    resetDut();
    applyStimulus(6'($urandom), 1'b0, 1'b0);
    #1;
    checkOutput("illFetchMain", obsMain, ctlWord(4'd0, 6'd0, 1'b0));
    checkOutput("illFetchHalt", obsHalt, ctlWord(4'd0, 6'd0, 1'b0));
    @(posedge clk); #2;
    applyStimulus(6'b111111, 1'b0, 1'b0);
    #1;
    checkOutput("illDecodeHalt", obsHalt, ctlWord(4'd1, 6'd0, 1'b0));
    @(posedge clk); #2;
    checkOutput("illPulseMain", obsMain, ctlWord(4'd0, 6'd0, 1'b1));
    checkOutput("illPulseHalt", obsHalt, ctlWord(4'd15, 6'd0, 1'b1));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(6'($urandom), 1'($urandom), 1'b0);
      @(posedge clk); #2;
      checkOutput($sformatf("haltStay%0d", i), obsHalt, ctlWord(4'd15, 6'd0, 1'b0));
    end
    resetDut();
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    int idx;
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI};
    applyStimulus(6'd0, 1'b0, 1'b1);
    resetDut();
    runInstr(OP_LW, 1'b0, -1);
    runInstr(OP_ANDI, 1'b1, -1);
    runInstr(OP_ADDI, 1'b0, -1);
    runInstr(OP_ORI, 1'b0, -1);
    runInstr(OP_BEQ, 1'b1, -1);
    runInstr(OP_BEQ, 1'b0, -1);
    runInstr(OP_SW, 1'b0, -1);
    runInstr(OP_RTYPE, 1'b1, -1);
    runInstr(OP_J, 1'b0, -1);
    runInstr(6'b111111, 1'b0, -1);
    runInstr(OP_LW, 1'b0, -1);
    illegalTest();
    runInstr(OP_SW, 1'b0, 3);
    runInstr(OP_LW, 1'b1, -1);
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 8);
      op  = (idx == 8) ? 6'($urandom) : ops[idx];
      runInstr(op, 1'($urandom), -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
